// File: rtl/input_array_pkg.sv
// Shared constants, widths and FSM state type for the skewed input array sequencer.
package input_array_pkg;
  localparam int LANES = 25;
  localparam int DW    = 16;
  localparam int LEN_W = 10;
  localparam int CNT_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } in_ctrl_state_t;
endpackage

// File: rtl/input_array_ctrl_if.sv
// Command, source handshake and array control bundle of the input array sequencer.
// Handshake: a row transfers in every cycle where src_vld and src_rdy are both high; src_rdy never depends on src_vld.
interface input_array_ctrl_if;
  import input_array_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             src_vld;
  logic             src_rdy;
  logic             fifo_en;
  logic             zero_fill;
  logic [LANES-1:0] out_vld;
  logic             busy;
  logic             done;
  logic             err_start;

  modport master (
    output start, len, abort, src_vld,
    input  src_rdy, fifo_en, zero_fill, out_vld, busy, done, err_start
  );

  modport slave (
    input  start, len, abort, src_vld,
    output src_rdy, fifo_en, zero_fill, out_vld, busy, done, err_start
  );
endinterface

// File: rtl/input_vld_skew.sv
// Per-lane valid mask: an enabled shift register that tracks which lanes hold real row data.
module input_vld_skew
  import input_array_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [LANES-1:0] vld
);
  logic [LANES-1:0] vsr_q;

  // Clear wins over advance so an abort leaves no stale valid bits behind.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vsr_q <= '0;
    end else if (clr) begin
      vsr_q <= '0;
    end else if (en) begin
      vsr_q <= {vsr_q[LANES-2:0], din};
    end
  end

  assign vld = vsr_q;
endmodule

// File: rtl/input_array_ctrl.sv
// Sequencer feeding the skewed input array: pulls len rows from the source, then drains the skew with zero rows.
module input_array_ctrl
  import input_array_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input_array_ctrl_if.slave  bus,
  output in_ctrl_state_t     dbg_state_o
);
  in_ctrl_state_t   state_q, state_d;
  logic [LEN_W-1:0] rows_left_q, rows_left_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             err_start_q, err_start_d;
  logic             feed;
  logic             advance;
  logic [LANES-1:0] vld;

  // src_rdy is decoded from FILL alone, so a feed is just src_vld while filling.
  assign feed    = (state_q == FILL) && bus.src_vld;
  assign advance = feed || (state_q == DRAIN);

  always_comb begin
    state_d     = state_q;
    rows_left_d = rows_left_q;
    drain_cnt_d = drain_cnt_q;
    err_start_d = bus.start && (state_q != IDLE);
    if (bus.abort) begin
      state_d     = IDLE;
      rows_left_d = '0;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              state_d     = FILL;
              rows_left_d = bus.len;
            end else begin
              state_d = DONE;
            end
          end
        end
        FILL: begin
          if (feed) begin
            rows_left_d = rows_left_q - LEN_W'(1);
            if (rows_left_q == LEN_W'(1)) begin
              state_d     = DRAIN;
              drain_cnt_d = CNT_W'(LANES);
            end
          end
        end
        DRAIN: begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
          if (drain_cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      rows_left_q <= '0;
      drain_cnt_q <= '0;
      err_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_left_q <= rows_left_d;
      drain_cnt_q <= drain_cnt_d;
      err_start_q <= err_start_d;
    end
  end

  input_vld_skew u_vld_skew (
    .clk  (clk),
    .nrst (nrst),
    .clr  (bus.abort),
    .en   (advance),
    .din  (feed),
    .vld  (vld)
  );

  assign bus.src_rdy   = (state_q == FILL);
  assign bus.fifo_en   = advance;
  assign bus.zero_fill = (state_q == DRAIN);
  assign bus.out_vld   = vld;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err_start = err_start_q;
  assign dbg_state_o   = state_q;
endmodule

// File: doc/input_array_ctrl.md
# input_array_ctrl

Sequencer for the 25-lane skewed input array that feeds the systolic PE grid. It accepts a tile-length command, pulls that many rows from the feature-map source through a valid/ready handshake, and drives the array's shift enable (`fifo_en`) and per-lane valid mask (`out_vld`). After the last row it drains the skew with zero rows and signals completion.

## Interface
- `LANES`, 25, number of array lanes; lane i lags lane 0 by i advances.
- `LEN_W`, 10, width of the row-count command.
- `clk`  in  1  clock, rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `len`  in  LEN_W  number of rows to feed; sampled with an accepted `start`.
- `abort`  in  1  synchronous abort; returns to IDLE next cycle.
- `src_vld`  in  1  source row present on the array `data_in` bus.
- `src_rdy`  out  1  controller accepts the row this cycle.
- `fifo_en`  out  1  array advance enable.
- `zero_fill`  out  1  select for the external mux that forces array `data_in` to 0 during drain.
- `out_vld`  out  LANES  per-lane valid mask; bit i high when lane i carries a valid row element.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err_start`  out  1  one-cycle pulse when `start` arrives while busy; the command is ignored.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: `start`=1 and `len`>0 → FILL; load `rows_left`=`len`. `start`=1 and `len`=0 → DONE with no `fifo_en`.
- FILL:
  - `src_rdy`=1.
  - `feed` = `src_vld` & `src_rdy`; `fifo_en` = `feed`.
  - Each `feed` decrements `rows_left`. The feed that takes `rows_left` from 1 to 0 → DRAIN, loading `drain_cnt`=LANES.
  - `src_vld`=0 stalls the whole array: `fifo_en`=0 and `out_vld` is held.
- DRAIN:
  - `fifo_en`=1, `zero_fill`=1, `src_rdy`=0.
  - `drain_cnt` decrements every cycle; at 1 → DONE.
- DONE: `done`=1 for one cycle → IDLE.
- Valid skew register `vsr[LANES-1:0]`, updated only when `fifo_en`=1:
  - `vsr[0]` <= `feed`
  - `vsr[i]` <= `vsr[i-1]`
  - `out_vld` = `vsr`
- `abort` has priority over every transition. Next cycle: IDLE, `vsr` cleared, no `done` pulse.
- `start` outside IDLE: `err_start` pulses for one cycle; state, counters and `len` are unaffected.
- Counters use `rows_left` at LEN_W bits and `drain_cnt` at $clog2(LANES+1) bits. Neither counter wraps, because transitions occur at count 1.

## Timing
- Reset values: state IDLE, `vsr`=0, counters 0. All outputs are 0: `src_rdy`, `fifo_en`, `zero_fill`, `out_vld`, `busy`, `done`, `err_start`.
- All outputs are registered or decoded from registered state. The only exception is `fifo_en` in FILL, which is combinational from `src_vld`.
- `start` accepted at cycle t → FILL at t+1, with `src_rdy`=1 at t+1.
- With `src_vld` held high, K rows occupy cycles t+1..t+K, DRAIN occupies t+K+1..t+K+LANES, and `done` is at t+K+LANES+1. `busy` falls in the same cycle `done` rises... correction: `busy` is 0 in the cycle after `done`.
- Lane i `out_vld` rises i+1 advances after the first feed and stays high for exactly K advances.
- At `done`, `out_vld`=0 in all lanes.
- `len`=0: `done` at t+1, zero advances.
- `start` in the same cycle as `done` is rejected because the state is not IDLE; `err_start` pulses.

## Structure
- Package `input_array_pkg` holds:
  - `LANES`=25 and `DW`=16.
  - `typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} in_ctrl_state_t`.
- One sub-module, `input_vld_skew`: the LANES-bit enabled shift register producing `out_vld`, with ports `clk`, `nrst`, `clr`, `en`, `din`, `vld[LANES-1:0]`.
- The FSM and counters stay in `input_array_ctrl`.

## Test plan
- Reset mid-FILL with `nrst` low for 1 cycle → all outputs 0 immediately, state IDLE. A subsequent `start` works normally.
- `len`=3, `src_vld` constant 1 → `fifo_en` high for 28 consecutive cycles. `out_vld[0]` is high for 3 advances; `out_vld[24]` rises on advance 25 and falls after advance 27. `done` arrives 29 cycles after `start`.
- `len`=4, `src_vld` pattern 1,0,0,1,1,0,1 → exactly 4 feeds. `fifo_en` and `out_vld` freeze on the 0 cycles. DRAIN lasts exactly 25 cycles.
- `len`=0 → `done` the next cycle; `fifo_en` never asserts.
- `start` during DRAIN → `err_start` pulse, no change to timing of `done`.
- `abort` in the cycle of the 2nd feed of a `len`=5 tile → IDLE next cycle, `out_vld`=0, no `done` pulse.
